// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int unsigned PC_INCR   = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry instruction/PC holding register used while IF/ID is stalled.
module if_skid_buffer
  import if_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // A flush or a drain into IF/ID always beats a new load.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: imem request handshake, next-PC selection and
// IF/ID pipeline registers with stall hold, skid buffer and branch flush.
//
// state | meaning
// FETCH | request at pc (or at the latched address while waiting)
// HOLD  | fetched word parked in the skid buffer, IF/ID stalled
// DRAIN | waiting out a request killed by a branch; its data is dropped
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall_in,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc
);

  fetch_state_e    state_q, state_d;
  logic            pending_q, pending_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;

  logic            req;
  logic [XLEN-1:0] req_addr;
  logic            buf_load, buf_clear, buf_valid;
  logic [31:0]     buf_instr;
  logic [XLEN-1:0] buf_pc;

  assign req      = (state_q != HOLD);
  assign req_addr = pending_q ? addr_q : pc;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    pc_next    = pc;

    // Latch the address on the first unanswered cycle so it stays stable even
    // though pc is not advanced; a branch in that cycle abandons the request.
    if (req && !pending_q && !imem_ready && !branch_taken) begin
      pending_d = 1'b1;
      addr_d    = pc;
    end
    if (req && imem_ready) begin
      pending_d = 1'b0;
    end

    if (branch_taken) begin
      pc_next    = branch_target;
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      buf_clear  = 1'b1;
      case (state_q)
        FETCH:   state_d = (pending_q && !imem_ready) ? DRAIN : FETCH;
        HOLD:    state_d = FETCH;
        DRAIN:   state_d = DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_next = pc + XLEN'(PC_INCR);
            if (stall_in) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end else begin
              if_valid_d = 1'b1;
              if_instr_d = imem_rdata;
              if_pc_d    = req_addr;
            end
          end else if (!stall_in) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            if_valid_d = buf_valid;
            if_instr_d = buf_instr;
            if_pc_d    = buf_pc;
            buf_clear  = 1'b1;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      pending_q  <= 1'b0;
      addr_q     <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      addr_q     <= addr_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  if_skid_buffer #(
    .XLEN(XLEN)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (buf_load),
    .clear    (buf_clear),
    .instr_in (imem_rdata),
    .pc_in    (req_addr),
    .valid    (buf_valid),
    .instr    (buf_instr),
    .pc       (buf_pc)
  );

  assign imem_req  = req;
  assign imem_addr = req_addr;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

endmodule
